adc_sample_sequencer: RTL

Sequences ADC conversions at a programmable rate. A free-running interval timer produces sample ticks, and each tick issues one ready/valid request to the ADC FSM. The block captures the returned sample, counts samples, and reports timeouts and overruns. The latest sample drives the board LEDs directly. It sits between the ADC FSM (GPIO side) and the LED bank and filter logic.

---
 rtl/adc_sample_sequencer_if.sv | 8 +
 rtl/adc_sample_sequencer.sv | 64 ++++++
 2 files changed

// File: rtl/adc_sample_sequencer_if.sv
// adc_sample_sequencer_if: ready/valid conversion handshake between the ADC FSM (master) and the sequencer (slave)
interface adc_sample_sequencer_if #(parameter int DATA_W = 10);
  logic              adc_conv_valid;
  logic [DATA_W-1:0] adc_data;
  logic              adc_conv_ready;
  modport master (output adc_conv_valid, adc_data, input adc_conv_ready);
  modport slave (input adc_conv_valid, adc_data, output adc_conv_ready);
endinterface

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: timer-paced ADC request sequencer with capture, sample count and sticky timeout/overrun flags
module adc_sample_sequencer #(
  parameter int DATA_W   = 10,
  parameter int PERIOD_W = 24,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr_err,
  adc_sample_sequencer_if.slave adc,
  output logic                sample_valid,
  output logic [DATA_W-1:0]   sample_data,
  output logic [9:0]          led_out,
  output logic [CNT_W-1:0]    sample_count,
  output logic                timeout_err,
  output logic                overrun
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, REQ} state_t;
  state_t              state, nxt;
  logic [PERIOD_W-1:0] tick_cnt, p_eff;
  logic [TO_W-1:0]     to_cnt;
  logic                tick, got, to_hit;
  always_comb begin
    p_eff  = (period == '0) ? PERIOD_W'(1) : period;
    tick   = (state != IDLE) && (tick_cnt >= p_eff - PERIOD_W'(1));
    got    = (state == REQ) && adc.adc_conv_valid;
    to_hit = (state == REQ) && !adc.adc_conv_valid && (to_cnt == TO_W'(TIMEOUT - 1));
    nxt    = !enable ? IDLE :
             (state == IDLE) ? WAIT :
             (state == WAIT) ? (tick ? REQ : WAIT) :
             (got || to_hit) ? WAIT : REQ;
  end
  assign led_out = sample_data[DATA_W-1 -: 10];
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      tick_cnt           <= '0;
      to_cnt             <= '0;
      adc.adc_conv_ready <= 1'b0;
      sample_valid       <= 1'b0;
      sample_data        <= '0;
      sample_count       <= '0;
      timeout_err        <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      state              <= nxt;
      adc.adc_conv_ready <= (nxt == REQ);
      sample_valid       <= got;
      if (got) begin
        sample_data  <= adc.adc_data;
        sample_count <= sample_count + CNT_W'(1);
      end
      // a tick landing on an open request is dropped, only flagged
      timeout_err <= (timeout_err & ~clr_err) | to_hit;
      overrun     <= (overrun & ~clr_err) | (tick && state == REQ);
      tick_cnt    <= (state == IDLE || !enable || tick) ? '0 : tick_cnt + PERIOD_W'(1);
      to_cnt      <= (state == REQ && !got && !to_hit) ? to_cnt + TO_W'(1) : '0;
    end
  end
endmodule
